// File: rtl/nic_pkg.sv
// Shared NIC definitions: packet geometry, field positions and the TX engine state type.
// The NIC buffer and the TX engine both import this package.
package nic_pkg;
  localparam int DATA_SIZE = 64;
  localparam int VC_BIT    = 63;
  localparam int PAYLOAD_MSB = VC_BIT - 1;
  localparam int PAYLOAD_LSB = 0;

  typedef enum logic {
    TX_EMPTY = 1'b0,
    TX_HELD  = 1'b1
  } tx_state_e;
endpackage

// File: rtl/nic_stall_watchdog.sv
// Saturating count of consecutive blocked cycles, with a registered flag
// that is set while the count sits at the limit.
module nic_stall_watchdog #(
  parameter int STALL_LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic blocked,
  output logic net_stall
);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STALL_LIMIT);

  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  logic          net_stall_q, net_stall_d;

  // A cycle that is not blocked is either a send or an empty hold; both clear the count.
  always_comb begin
    stall_cnt_d = '0;
    if (blocked) begin
      stall_cnt_d = (stall_cnt_q == LIMIT) ? stall_cnt_q : stall_cnt_q + SW'(1);
    end
    net_stall_d = (stall_cnt_d == LIMIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      net_stall_q <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      net_stall_q <= net_stall_d;
    end
  end

  assign net_stall = net_stall_q;
endmodule

// File: rtl/nic_tx_engine.sv
// Drains the single-entry NIC buffer into a 1-deep hold register and launches
// each packet onto the router link with a registered valid pulse.
module nic_tx_engine
  import nic_pkg::*;
#(
  parameter int DATA_SIZE   = nic_pkg::DATA_SIZE,
  parameter int VC_BIT      = nic_pkg::VC_BIT,
  parameter int STALL_LIMIT = 255,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 buf_status,
  input  logic [DATA_SIZE-1:0] buf_data,
  output logic                 buf_re,
  input  logic                 net_ro,
  input  logic                 polarity,
  output logic                 net_so,
  output logic [DATA_SIZE-1:0] net_do,
  output logic                 net_stall,
  output logic [CNT_W-1:0]     sent_cnt
);
  tx_state_e              state_q, state_d;
  logic [DATA_SIZE-1:0]   hold_q, hold_d;
  logic                   net_so_q, net_so_d;
  logic [DATA_SIZE-1:0]   net_do_q, net_do_d;
  logic [CNT_W-1:0]       sent_cnt_q, sent_cnt_d;
  logic                   hold_full, vc_ok, send_now, blocked;

  assign hold_full = (state_q == TX_HELD);
  assign vc_ok     = (hold_q[VC_BIT] == polarity);
  assign send_now  = hold_full & net_ro & vc_ok;
  assign blocked   = hold_full & ~send_now;
  // The buffer clears its status on the edge that consumes the read, so a
  // refill during a send launches the old packet and loads the new one together.
  assign buf_re    = buf_status & (~hold_full | send_now) & ~reset;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    net_so_d   = 1'b0;
    net_do_d   = net_do_q;
    sent_cnt_d = sent_cnt_q;
    if (send_now) begin
      net_do_d   = hold_q;
      net_so_d   = 1'b1;
      sent_cnt_d = sent_cnt_q + CNT_W'(1);
    end
    if (buf_re) begin
      hold_d  = buf_data;
      state_d = TX_HELD;
    end else if (send_now) begin
      state_d = TX_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= TX_EMPTY;
      hold_q     <= '0;
      net_so_q   <= 1'b0;
      net_do_q   <= '0;
      sent_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      net_so_q   <= net_so_d;
      net_do_q   <= net_do_d;
      sent_cnt_q <= sent_cnt_d;
    end
  end

  nic_stall_watchdog #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .blocked  (blocked),
    .net_stall(net_stall)
  );

  assign net_so   = net_so_q;
  assign net_do   = net_do_q;
  assign sent_cnt = sent_cnt_q;
endmodule

// File: tb/tb_nic_tx_engine.sv
// Directed bench for nic_tx_engine: latency, VC/polarity gating, back-to-back
// launch, stall watchdog, async reset and sent-counter wrap.
module tb_nic_tx_engine;
  logic        clk = 1'b0;
  logic        reset;
  logic        buf_status;
  logic [63:0] buf_data;
  logic        buf_re;
  logic        net_ro;
  logic        polarity;
  logic        net_so;
  logic [63:0] net_do;
  logic        net_stall;
  logic [15:0] sent_cnt;

  int total = 0;
  int bad   = 0;

  nic_tx_engine #(
    .DATA_SIZE(64), .VC_BIT(63), .STALL_LIMIT(255), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .buf_status(buf_status), .buf_data(buf_data),
    .buf_re(buf_re), .net_ro(net_ro), .polarity(polarity), .net_so(net_so),
    .net_do(net_do), .net_stall(net_stall), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks happen 1ns after that.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  localparam logic [63:0] VC1 = 64'h8000_0000_0000_0000;

  initial begin
    reset = 1'b1; buf_status = 1'b0; buf_data = '0; net_ro = 1'b0; polarity = 1'b0;
    #12;
    chk("rst_so", net_so, 0);
    chk("rst_do", net_do, 0);
    chk("rst_stall", net_stall, 0);
    chk("rst_cnt", sent_cnt, 0);
    @(negedge clk); reset = 1'b0;
    tick();

    // 1: basic latency
    buf_status = 1; buf_data = 64'hA5; net_ro = 1; polarity = 0;
    settle();
    chk("t1_re", buf_re, 1);
    tick(); buf_status = 0; settle();
    chk("t1_so_c1", net_so, 0);
    tick(); settle();
    chk("t1_so", net_so, 1);
    chk("t1_do", net_do, 64'hA5);
    chk("t1_cnt", sent_cnt, 1);
    tick(); settle();
    chk("t1_pulse", net_so, 0);

    // 2: VC mismatch holds the packet until polarity flips
    buf_status = 1; buf_data = VC1 | 64'h22; settle();
    tick(); buf_data = VC1 | 64'h33; settle();
    for (int i = 0; i < 3; i++) begin
      chk("t2_re_held", buf_re, 0);
      tick(); settle();
      chk("t2_so_blk", net_so, 0);
    end
    polarity = 1; settle();
    chk("t2_re_swap", buf_re, 1);
    tick(); buf_status = 0; settle();
    chk("t2_so", net_so, 1);
    chk("t2_do", net_do, VC1 | 64'h22);
    tick(); settle();
    chk("t2_so2", net_so, 1);
    chk("t2_do2", net_do, VC1 | 64'h33);
    chk("t2_cnt", sent_cnt, 3);
    tick(); settle();
    chk("t2_end", net_so, 0);

    // 3: back-to-back refill 1..4
    polarity = 0;
    buf_status = 1; buf_data = 64'd1; settle();
    chk("t3_re0", buf_re, 1);
    tick();
    for (int k = 2; k <= 5; k++) begin
      if (k <= 4) buf_data = 64'(k); else buf_status = 0;
      settle();
      chk("t3_re", buf_re, (k <= 4) ? 1 : 0);
      tick(); settle();
      chk("t3_so", net_so, 1);
      chk("t3_do", net_do, 64'(k - 1));
    end
    tick(); settle();
    chk("t3_gap", net_so, 0);
    chk("t3_cnt", sent_cnt, 7);

    // 4: stall watchdog
    net_ro = 0; buf_status = 1; buf_data = 64'h44; settle();
    tick(); buf_status = 0; settle();
    chk("t4_load", net_stall, 0);
    for (int c = 1; c <= 300; c++) begin
      tick(); settle();
      if (c == 254) chk("t4_pre", net_stall, 0);
      if (c == 255) chk("t4_rise", net_stall, 1);
      if (c == 300) chk("t4_hold", net_stall, 1);
    end
    chk("t4_noso", net_so, 0);
    net_ro = 1; settle();
    tick(); settle();
    chk("t4_so", net_so, 1);
    chk("t4_do", net_do, 64'h44);
    chk("t4_clear", net_stall, 0);
    tick(); settle();

    // 5: async reset while HELD
    net_ro = 0; buf_status = 1; buf_data = 64'h55; settle();
    tick(); buf_status = 1; buf_data = 64'h66; #2;
    reset = 1'b1; #1;
    chk("t5_do", net_do, 0);
    chk("t5_cnt", sent_cnt, 0);
    chk("t5_so", net_so, 0);
    chk("t5_re", buf_re, 0);
    buf_status = 0; net_ro = 1;
    @(negedge clk); reset = 1'b0;
    tick(); settle();
    chk("t5_nosend1", net_so, 0);
    tick(); settle();
    chk("t5_nosend2", net_so, 0);
    chk("t5_cnt2", sent_cnt, 0);

    // 6: counter wrap
    polarity = 0; net_ro = 1; buf_status = 1; buf_data = 64'h7;
    tick();
    repeat (65535) tick();
    settle();
    chk("t6_max", sent_cnt, 16'hFFFF);
    tick(); settle();
    chk("t6_wrap", sent_cnt, 0);
    chk("t6_so", net_so, 1);
    buf_status = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
